// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains an FWFT fifo into a valid/ready stream
// through a 2-entry head/skid buffer, with flush and transfer counter.
module fifo_stream_reader #(
  parameter int WIDTH = 16,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_re,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy,
  output logic [CW-1:0]    xfer_count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       occ;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic             acc;

  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid & m_ready;
  // Registered state only: m_ready never reaches the fifo read strobe.
  assign fifo_re    = !rst & !flush & !fifo_empty & (occ != 2'd2);
  assign acc        = fifo_re;
  assign m_data     = head;
  assign occupancy  = occ;
  assign xfer_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop)
        cnt <= cnt + CW'(1);
      if (flush)
        occ <= 2'd0;
      else
        occ <= occ + {1'b0, acc} - {1'b0, pop};
      if (occ == 2'd2 && pop)
        head <= tail;
      else if (acc && (occ == 2'd0 || pop))
        head <= fifo_data;
      if (acc && occ == 2'd1 && !pop)
        tail <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based fifo and buffer model,
// per-cycle compare plus directed literal checks.
module tb_fifo_stream_reader;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_re;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] xfer_count;

  fifo_stream_reader #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_re(fifo_re),
    .flush(flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .occupancy(occupancy),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] mb[$];
  logic [W-1:0] got[$];
  int cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  // Model: fifo queue feeds a buffer of at most two words.
  always @(posedge clk) begin
    bit p;
    bit a;
    if (rst) begin
      mb.delete();
      fq.delete();
      cnt = 0;
    end else begin
      p = (mb.size() != 0) && m_ready;
      a = !flush && (fq.size() != 0) && (mb.size() < 2);
      if (p) begin
        got.push_back(mb.pop_front());
        cnt++;
      end
      if (a)
        mb.push_back(fq.pop_front());
      if (flush)
        mb.delete();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_re", 32'(fifo_re),
            32'(!rst && !flush && fq.size() != 0 && mb.size() < 2));
      check("m_valid", 32'(m_valid), 32'(mb.size() != 0));
      check("occupancy", 32'(occupancy), 32'(mb.size()));
      check("xfer_count", 32'(xfer_count), 32'(cnt % 16));
      if (mb.size() != 0)
        check("m_data", 32'(m_data), 32'(mb[0]));
    end
  end

  initial begin
    int nre;
    int g0;
    rst     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    refresh();
    repeat (2) tick();
    chk_en = 1;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_xfer", 32'(xfer_count), 0);

    // basic stream of four words
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(W'(i));
    #1;
    check("t1_re", 32'(fifo_re), 1);
    check("t1_lat0", 32'(m_valid), 0);
    tick();
    #1;
    check("t1_lat1", 32'(m_valid), 1);
    check("t1_first", 32'(m_data), 32'h1);
    repeat (6) tick();
    #1;
    check("t1_xfer", 32'(xfer_count), 4);
    check("t1_ngot", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("t1_order", 32'(got[i]), 32'(i + 1));

    // back-pressure with six preloaded words
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(W'(16'h10 + i));
    nre = 0;
    repeat (5) begin
      #1;
      if (fifo_re) nre++;
      tick();
    end
    #1;
    check("t2_nre", nre, 2);
    check("t2_occ", 32'(occupancy), 2);
    check("t2_head", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    repeat (6) tick();
    #1;
    check("t2_burst", 32'(xfer_count), 10);
    check("t2_ngot", got.size(), 10);
    for (int i = 0; i < 6 && 4 + i < got.size(); i++)
      check("t2_order", 32'(got[4 + i]), 32'(16'h10 + i));

    // toggled ready over eight words after a reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    g0 = got.size();
    for (int i = 0; i < 8; i++) push(W'(16'h20 + i));
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    #1;
    check("t3_xfer", 32'(xfer_count), 8);
    check("t3_ngot", got.size() - g0, 8);
    for (int i = 0; i < 8 && g0 + i < got.size(); i++)
      check("t3_order", 32'(got[g0 + i]), 32'(16'h20 + i));

    // flush with a full buffer
    m_ready = 1'b0;
    push(16'h30);
    push(16'h31);
    push(16'h32);
    repeat (3) tick();
    #1;
    check("t4_occ2", 32'(occupancy), 2);
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    check("t4_re_flush", 32'(fifo_re), 0);
    tick();
    flush   = 1'b0;
    m_ready = 1'b0;
    #1;
    check("t4_occ0", 32'(occupancy), 0);
    check("t4_valid0", 32'(m_valid), 0);
    check("t4_xfer", 32'(xfer_count), 9);
    check("t4_resume_re", 32'(fifo_re), 1);
    check("t4_delivered", 32'(got[got.size() - 1]), 32'h30);
    tick();
    #1;
    check("t4_next", 32'(m_data), 32'h32);

    // reset mid-stream with a full buffer
    push(16'h40);
    push(16'h41);
    repeat (2) tick();
    #1;
    check("t5_occ2", 32'(occupancy), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_valid", 32'(m_valid), 0);
    check("t5_data", 32'(m_data), 0);
    check("t5_occ", 32'(occupancy), 0);
    check("t5_xfer", 32'(xfer_count), 0);

    // counter wrap: 17 words through a 4-bit counter
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(W'(16'h50 + i));
    repeat (22) tick();
    #1;
    check("t6_wrap", 32'(xfer_count), 1);
    check("t6_last", 32'(got[got.size() - 1]), 32'h60);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
